// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states,
// default memory size and the alignment check used at request accept.
package lsu_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 1024;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MERGE,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  // True when the size/offset pair cannot be served by one aligned word
  // access. The reserved size is treated as always illegal.
  function automatic logic access_misaligned(input logic [1:0] size,
                                             input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Purely combinational little-endian lane steering. The load path pulls the
// addressed byte/halfword out of a memory word and extends it; the store path
// splices new data into an old word so a sub-word store can be written back
// as a full word.
module lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  // Select the addressed lane and sign- or zero-extend it.
  function automatic logic [31:0] extract_ext(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = {{24{b[7] & ~uns}}, b};
      SZ_HALF: res = {{16{h[15] & ~uns}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane(s) of the old word with the low store bits.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                             input logic [31:0] new_data,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size);
    logic [31:0] res;
    res = old_word;
    case (size)
      SZ_BYTE: begin
        for (int k = 0; k < 4; k++) begin
          if (off == 2'(k)) res[8*k +: 8] = new_data[7:0];
        end
      end
      SZ_HALF: begin
        if (off[1]) res[31:16] = new_data[15:0];
        else        res[15:0]  = new_data[15:0];
      end
      default: res = new_data;
    endcase
    return res;
  endfunction

  // Both paths are evaluated continuously; the FSM decides which one to use.
  always_comb begin
    load_o  = extract_ext(word_i, offset_i, size_i, unsigned_i);
    merge_o = merge_lane(word_i, wdata_i, offset_i, size_i);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-only data memory.
// Loads take one memory read cycle, word stores one write cycle, and sub-word
// stores do a read-modify-write. Faulting requests answer without touching
// memory. All memory-side outputs are registered so a reset removes them
// immediately and no write can slip out of an aborted access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        MemWrite,
  output logic [31:0] ALUResult,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  lsu_state_e  state_q;

  // Latched request; wbuf_q starts as the store data and becomes the merged
  // word for sub-word stores.
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] wbuf_q;

  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_fault_q;
  logic        mem_write_q;
  logic [31:0] alu_result_q;
  logic [31:0] write_data_q;

  logic        fault_d;
  logic [31:0] req_aligned_d;
  logic [31:0] held_aligned_d;
  logic [31:0] load_data_d;
  logic [31:0] merge_data_d;

  lane_align u_lane_align (
    .word_i     (ReadData),
    .wdata_i    (wbuf_q),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .load_o     (load_data_d),
    .merge_o    (merge_data_d)
  );

  // Fault decision and word-aligned addresses for the incoming and held request.
  always_comb begin
    fault_d        = access_misaligned(req_size, req_addr[1:0]) ||
                     (req_addr >= MEM_BYTES);
    req_aligned_d  = {req_addr[31:2], 2'b00};
    held_aligned_d = {addr_q[31:2], 2'b00};
  end

  // Sequencer: each transition also loads the outputs for the state entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      wbuf_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_fault_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_result_q <= '0;
      write_data_q <= '0;
    end else begin
      rsp_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_result_q <= '0;
      write_data_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            wbuf_q     <= req_wdata;
            if (fault_d) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (!req_write) begin
              state_q      <= ST_READ;
              alu_result_q <= req_aligned_d;
            end else if (req_size == SZ_WORD) begin
              state_q      <= ST_WRITE;
              alu_result_q <= req_aligned_d;
              mem_write_q  <= 1'b1;
              write_data_q <= req_wdata;
            end else begin
              state_q      <= ST_MERGE;
              alu_result_q <= req_aligned_d;
            end
          end
        end
        ST_READ: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_fault_q <= 1'b0;
          rsp_rdata_q <= load_data_d;
        end
        ST_MERGE: begin
          state_q      <= ST_WRITE;
          wbuf_q       <= merge_data_d;
          alu_result_q <= held_aligned_d;
          mem_write_q  <= 1'b1;
          write_data_q <= merge_data_d;
        end
        ST_WRITE: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_fault_q <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;
  assign MemWrite  = mem_write_q;
  assign ALUResult = alu_result_q;
  assign WriteData = write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  logic [31:0] mem [0:255];
  int          wr_cnt = 0;
  int          rsp_cnt = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault),
    .MemWrite     (MemWrite),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .ReadData     (ReadData)
  );

  always #5 clk = ~clk;

  assign ReadData = (ALUResult < 32'd1024) ? mem[ALUResult[9:2]] : 32'd0;

  always @(posedge clk) begin
    if (MemWrite) begin
      mem[ALUResult[9:2]] <= WriteData;
      wr_cnt++;
      last_wr_addr = ALUResult;
      last_wr_data = WriteData;
    end
    if (rsp_valid) rsp_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one request in IDLE, release it after accept, then wait for the
  // response. lat = cycles from accept edge to rsp_valid, or 0 when no
  // response arrives within eight cycles.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic f);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = '0; f = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i; rd = rsp_rdata; f = rsp_fault;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    int          exp_writes;
    logic [31:0] exp_wr_data;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        f;
    int          wr0;
    int          rsp0;
    logic [31:0] exp_addr;
    logic        exp_ready [1:5];
    logic        exp_rv    [1:5];
    logic [31:0] exp_rd    [1:5];

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    //           name        w   sz     u   addr   wdata          rdata          flt lat wr wrdata
    vecs.push_back('{"sw4",   1, 2'b10, 0, 32'd4,  32'h000005DC, 32'h0,         0, 2, 1, 32'h000005DC});
    vecs.push_back('{"lw4",   0, 2'b10, 0, 32'd4,  32'h0,        32'h000005DC,  0, 2, 0, 32'h0});
    vecs.push_back('{"sw4b",  1, 2'b10, 0, 32'd4,  32'h11223344, 32'h0,         0, 2, 1, 32'h11223344});
    vecs.push_back('{"sb5",   1, 2'b00, 0, 32'd5,  32'h123456AB, 32'h0,         0, 3, 1, 32'h1122AB44});
    vecs.push_back('{"lw4m",  0, 2'b10, 0, 32'd4,  32'h0,        32'h1122AB44,  0, 2, 0, 32'h0});
    vecs.push_back('{"lbu5",  0, 2'b00, 1, 32'd5,  32'h0,        32'h000000AB,  0, 2, 0, 32'h0});
    vecs.push_back('{"lb5",   0, 2'b00, 0, 32'd5,  32'h0,        32'hFFFFFFAB,  0, 2, 0, 32'h0});
    vecs.push_back('{"lbu7",  0, 2'b00, 1, 32'd7,  32'h0,        32'h00000011,  0, 2, 0, 32'h0});
    vecs.push_back('{"lb4",   0, 2'b00, 0, 32'd4,  32'h0,        32'h00000044,  0, 2, 0, 32'h0});
    vecs.push_back('{"sw8",   1, 2'b10, 0, 32'd8,  32'h8001BEEF, 32'h0,         0, 2, 1, 32'h8001BEEF});
    vecs.push_back('{"lh10",  0, 2'b01, 0, 32'd10, 32'h0,        32'hFFFF8001,  0, 2, 0, 32'h0});
    vecs.push_back('{"lhu10", 0, 2'b01, 1, 32'd10, 32'h0,        32'h00008001,  0, 2, 0, 32'h0});
    vecs.push_back('{"sh8",   1, 2'b01, 0, 32'd8,  32'h5555CAFE, 32'h0,         0, 3, 1, 32'h8001CAFE});
    vecs.push_back('{"lh8",   0, 2'b01, 0, 32'd8,  32'h0,        32'hFFFFCAFE,  0, 2, 0, 32'h0});
    vecs.push_back('{"lw6",   0, 2'b10, 0, 32'd6,  32'h0,        32'h0,         1, 1, 0, 32'h0});
    vecs.push_back('{"lh3",   0, 2'b01, 0, 32'd3,  32'h0,        32'h0,         1, 1, 0, 32'h0});
    vecs.push_back('{"rsvd",  0, 2'b11, 0, 32'd0,  32'h0,        32'h0,         1, 1, 0, 32'h0});
    vecs.push_back('{"lw1024",0, 2'b10, 0, 32'd1024,32'h0,       32'h0,         1, 1, 0, 32'h0});
    vecs.push_back('{"sw1024",1, 2'b10, 0, 32'd1024,32'hDEADBEEF,32'h0,         1, 1, 0, 32'h0});
    vecs.push_back('{"sb_oob",1, 2'b00, 0, 32'd2000,32'h000000FF,32'h0,         1, 1, 0, 32'h0});

    // Reset state while rst_n is asserted, then after release.
    #12;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_fault", {31'b0, rsp_fault}, 32'd0);
    chk("rst_memwrite", {31'b0, MemWrite}, 32'd0);
    chk("rst_aluresult", ALUResult, 32'd0);
    chk("rst_writedata", WriteData, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // Table-driven single transactions.
    foreach (vecs[i]) begin
      wr0 = wr_cnt;
      run_req(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].addr, vecs[i].wdata, lat, rd, f);
      @(negedge clk);
      exp_addr = {vecs[i].addr[31:2], 2'b00};
      $display("txn %-7s w=%0d sz=%0d u=%0d addr=%h wdata=%h -> lat=%0d rdata=%h fault=%0d writes=%0d",
               vecs[i].name, vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].addr, vecs[i].wdata,
               lat, rd, f, wr_cnt - wr0);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      chk({vecs[i].name, "_fault"}, {31'b0, f}, {31'b0, vecs[i].exp_fault});
      chk({vecs[i].name, "_writes"}, 32'(wr_cnt - wr0), 32'(vecs[i].exp_writes));
      if (vecs[i].exp_writes == 1) begin
        chk({vecs[i].name, "_wr_addr"}, last_wr_addr, exp_addr);
        chk({vecs[i].name, "_wr_data"}, last_wr_data, vecs[i].exp_wr_data);
      end
    end

    // Reset landing in MERGE of a byte store must leave memory untouched.
    run_req(1'b1, 2'b10, 1'b0, 32'd12, 32'hA5A5A5A5, lat, rd, f);
    chk("sw12_lat", 32'(lat), 32'd2);
    @(negedge clk);
    wr0 = wr_cnt; rsp0 = rsp_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd12; req_wdata = 32'h00000077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("merge_aluresult", ALUResult, 32'd12);
    chk("merge_memwrite", {31'b0, MemWrite}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort_rdata", rsp_rdata, 32'd0);
    chk("abort_fault", {31'b0, rsp_fault}, 32'd0);
    chk("abort_memwrite", {31'b0, MemWrite}, 32'd0);
    chk("abort_aluresult", ALUResult, 32'd0);
    chk("abort_writedata", WriteData, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("txn abort   sb addr=0000000c during MERGE -> writes=%0d rsps=%0d mem=%h",
             wr_cnt - wr0, rsp_cnt - rsp0, mem[3]);
    chk("abort_writes", 32'(wr_cnt - wr0), 32'd0);
    chk("abort_rsps", 32'(rsp_cnt - rsp0), 32'd0);
    chk("abort_mem12", mem[3], 32'hA5A5A5A5);
    run_req(1'b0, 2'b10, 1'b0, 32'd12, 32'h0, lat, rd, f);
    chk("lw12_after_abort", rd, 32'hA5A5A5A5);

    // Back-to-back loads with req_valid held: accept every third edge.
    exp_ready = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_rv    = '{1'b1 ? 1'b0 : 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_rd    = '{32'h0, 32'h1122AB44, 32'h0, 32'h0, 32'h8001CAFE};
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'd4;
    @(posedge clk);
    #1 req_addr = 32'd8;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      $display("txn b2b     cycle=%0d ready=%0d rsp_valid=%0d rdata=%h",
               k, req_ready, rsp_valid, rsp_rdata);
      chk($sformatf("b2b_ready_c%0d", k), {31'b0, req_ready}, {31'b0, exp_ready[k]});
      chk($sformatf("b2b_rsp_valid_c%0d", k), {31'b0, rsp_valid}, {31'b0, exp_rv[k]});
      if (exp_rv[k]) chk($sformatf("b2b_rdata_c%0d", k), rsp_rdata, exp_rd[k]);
      if (k == 3) begin
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_idle_ready", {31'b0, req_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
